// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check controller and its stall timer.
package sysid_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sysid_stall_timer.sv
// Counts consecutive waitrequest cycles of one read and flags the cycle in which
// the stall limit is reached, so the controller can abandon that read.
module sysid_stall_timer
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [STALL_CNT_W-1:0] LAST_STALL = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall) begin
      count <= count + 1'b1;
    end
  end

  // The stall cycle that would bring the count to the limit is the last one tolerated.
  assign expired = stall && (count == LAST_STALL);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM master that reads the system-ID word and timestamp and reports a verdict.
// Optional stall timeout is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1495887352,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_check_ctrl: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t state, next_state;
  logic   pending;
  logic   go;
  logic   leave_idle;
  logic   rd_done;
  logic   expired;
  logic   timeout_q;

  assign go         = start || pending;
  assign leave_idle = (state == IDLE) && go;
  assign rd_done    = avm_read && !avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic stall;
  assign stall = avm_read && avm_waitrequest;

  sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (leave_idle || rd_done),
    .stall   (stall),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = RD_ID;
      RD_ID:   if (rd_done) next_state = RD_TS;
               else if (expired) next_state = REPORT;
      RD_TS:   if (rd_done || expired) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus strobes and status come from the state register alone, so reset drops them at once.
  always_comb begin
    avm_read    = 1'b0;
    avm_address = SYSID_ADDR_ID;
    busy        = (state != IDLE);
    done        = (state == REPORT);
    case (state)
      RD_ID: avm_read = 1'b1;
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_TS;
      end
      default: ;
    endcase
  end

  // Verdict flags settle on the edge into REPORT; the timestamp is compared straight off the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= AUTO_START;
      id_value  <= '0;
      ts_value  <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      pass      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          pending   <= 1'b0;
          id_value  <= '0;
          ts_value  <= '0;
          id_ok     <= 1'b0;
          ts_ok     <= 1'b0;
          pass      <= 1'b0;
          timeout_q <= 1'b0;
        end
        RD_ID: begin
          if (rd_done) begin
            id_value <= avm_readdata;
          end else if (expired) begin
            timeout_q <= 1'b1;
          end
        end
        RD_TS: begin
          if (rd_done) begin
            ts_value <= avm_readdata;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (avm_readdata == EXPECTED_TS);
            pass     <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
          end else if (expired) begin
            timeout_q <= 1'b1;
            id_ok     <= (id_value == EXPECTED_ID);
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout = timeout_q;

endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Avalon-MM master controller that sequences reads of the system-ID slave and checks them. After reset, or on request, it reads the ID word at address 0, then the timestamp word at address 1. It compares both words against build-time expected values and holds a pass/fail verdict for the boot logic and the game controller. The block sits between the boot/reset sequencer and the system-ID slave's control port, and is the only master driving that port.

## Interface
- EXPECTED_ID, default 0: expected word at address 0.
- EXPECTED_TS, default 1495887352: expected word at address 1.
- AUTO_START, default 1: 1 = run one check automatically after reset release.
- TIMEOUT_CYCLES, default 255, range 1..65535: stall limit; used only with SYSID_CHECK_TIMEOUT_EN.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a check; sampled only in IDLE.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; read completes when avm_read=1 and avm_waitrequest=0.
- avm_readdata  in  32  valid in the completing cycle (zero read latency).
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse; verdict valid.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- pass  out  1  id_ok & ts_ok & !timeout.
- timeout  out  1  the last check aborted on a stall.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

## Operation
- States: IDLE, RD_ID, RD_TS, REPORT.
- IDLE:
  - Go to RD_ID when start=1 or the auto-start pending flag is set.
  - On leaving IDLE, clear id_ok, ts_ok, pass and timeout, and clear the pending flag.
- RD_ID:
  - avm_read=1, avm_address=0.
  - On completion, capture avm_readdata into id_value and go to RD_TS.
- RD_TS:
  - avm_read=1, avm_address=1.
  - On completion, capture avm_readdata into ts_value and go to REPORT.
- REPORT:
  - done=1; id_ok, ts_ok and pass are registered on entry.
  - Go to IDLE unconditionally.
- avm_read, avm_address, busy and done decode from the state register only, with no combinational path from inputs.
  - busy = state != IDLE.
  - avm_address is 0 outside RD_TS.
- start is ignored while busy; it is not queued, including a start in the REPORT cycle.
- The auto-start pending flag resets to AUTO_START.
- Comparisons are full 32-bit equality.

## Timing
- Reset values: all outputs 0, state IDLE. Captured values and flags are cleared.
- Reset mid-check: avm_read deasserts asynchronously and no done is produced. With AUTO_START=1 the check restarts after release.
- Latency: start high at edge k, zero wait states:
  - RD_ID during cycle k+1.
  - RD_TS during cycle k+2.
  - done and verdict visible during cycle k+3.
  - busy is high from k+1 through k+3.
- Each wait-state cycle adds exactly one cycle. avm_address and avm_read stay stable while waitrequest=1.
- Auto-start: the first check begins in the first cycle after reset release (RD_ID in cycle 1).
- id_value, ts_value and the flags hold until the next check starts.

## Configuration
- SYSID_CHECK_TIMEOUT_EN defined:
  - A 16-bit stall counter counts cycles in RD_ID/RD_TS with avm_waitrequest=1.
  - The counter clears on each completed read and on leaving IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the read is abandoned and the block goes to REPORT with timeout=1 and pass=0. Uncaptured words read 0 and their ok flags are 0.
- Not defined:
  - The block waits indefinitely.
  - The timeout output is tied 0 and the counter is absent.

## Structure
- Package sysid_check_pkg holds:
  - state enum;
  - SYSID_ADDR_ID = 1'b0, SYSID_ADDR_TS = 1'b1;
  - stall counter width (16).
- One sub-module: sysid_stall_timer, which holds the stall counter and compare. It is instantiated only under SYSID_CHECK_TIMEOUT_EN.

## Test plan
- AUTO_START=1, slave returns 0 / 1495887352, waitrequest=0:
  - avm_read high in cycles 1–2 with address 0 then 1;
  - done in cycle 3 with id_ok=ts_ok=pass=1.
- Manual start, slave timestamp 1495887353 -> ts_ok=0, pass=0, ts_value=1495887353, id_ok=1.
- waitrequest high for 3 cycles on each read:
  - done exactly 6 cycles later than with zero wait states;
  - address and read held stable during stalls.
- start pulsed during RD_TS and during REPORT -> ignored; exactly one done, then IDLE.
- reset_n low during RD_ID -> avm_read 0 immediately and all outputs 0; after release (AUTO_START=1) a full check completes normally.
- SYSID_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> done after 4 stall cycles with timeout=1, pass=0, id_value=0.
